// File: rtl/bsg_serial_in_parallel_out_full.sv
// bsg_serial_in_parallel_out_full: collects els_p serial words into one parallel word.
// Set BSG_SIPO_ASSERT_EN to build in the simulation-only checks.
module bsg_serial_in_parallel_out_full #(
    parameter int width_p = -1,
    parameter int els_p = -1,
    parameter int hi_to_lo_p = 0,
    parameter int use_minimal_buffering_p = 0
) (
    input  logic                            clk_i,
    input  logic                            reset_i,
    input  logic                            valid_i,
    input  logic [width_p-1:0]              data_i,
    output logic                            ready_o,
    output logic                            valid_o,
    output logic [els_p-1:0][width_p-1:0]   data_o,
    input  logic                            yumi_i
);
    localparam int ctr_w = (els_p > 1) ? $clog2(els_p) : 1;
    localparam logic [ctr_w-1:0] last_idx = ctr_w'(els_p - 1);

    logic [els_p-1:0][width_p-1:0] collect, collect_n;
    logic [ctr_w-1:0] wr_ctr, wr_idx;
    logic collect_full_r, accept, last;

    assign ready_o = ~collect_full_r & ~reset_i;
    assign accept = valid_i & ready_o;
    assign last = accept & (wr_ctr == last_idx);
    assign wr_idx = (hi_to_lo_p != 0) ? last_idx - wr_ctr : wr_ctr;

    // collect vector with the current word merged in, so a finishing word can bypass to the output
    always_comb begin
        collect_n = collect;
        collect_n[wr_idx] = data_i;
    end

    // store accepted words and advance the write position, wrapping after the last word
    always_ff @(posedge clk_i) begin
        if (reset_i)
            wr_ctr <= '0;
        else if (accept)
            wr_ctr <= last ? '0 : wr_ctr + 1'b1;
        if (accept)
            collect <= collect_n;
    end

    if (use_minimal_buffering_p != 0) begin : g_min
        // single slot: the collect array is presented directly once complete
        always_ff @(posedge clk_i) begin
            if (reset_i)
                collect_full_r <= 1'b0;
            else if (last)
                collect_full_r <= 1'b1;
            else if (yumi_i)
                collect_full_r <= 1'b0;
        end
        assign valid_o = collect_full_r & ~reset_i;
        assign data_o = collect;
    end else begin : g_full
        logic [els_p-1:0][width_p-1:0] out_data_r;
        logic out_v_r, out_free;
        assign out_free = ~out_v_r | yumi_i;
        // move a finished set into the output register whenever it is free, else park it in collect
        always_ff @(posedge clk_i) begin
            if (reset_i) begin
                collect_full_r <= 1'b0;
                out_v_r <= 1'b0;
            end else if (collect_full_r & out_free) begin
                out_data_r <= collect;
                collect_full_r <= 1'b0;
                out_v_r <= 1'b1;
            end else if (last & out_free) begin
                out_data_r <= collect_n;
                out_v_r <= 1'b1;
            end else if (last)
                collect_full_r <= 1'b1;
            else if (yumi_i)
                out_v_r <= 1'b0;
        end
        assign valid_o = out_v_r & ~reset_i;
        assign data_o = out_data_r;
    end

`ifdef BSG_SIPO_ASSERT_EN
    initial if (width_p < 1 || els_p < 1) $fatal(1, "bsg_sipo: width_p and els_p must be >= 1");
    // protocol sanity checks, quiet during reset
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            if (yumi_i & ~valid_o) $error("bsg_sipo: yumi_i while valid_o low");
            if (collect_full_r & ready_o) $error("bsg_sipo: ready_o high with full collect buffer");
        end
    end
`else
`endif
endmodule

// File: tb/tb_bsg_serial_in_parallel_out_full.sv
// tb_bsg_serial_in_parallel_out_full: scoreboard bench over lo/hi ordering and minimal buffering.
module tb_bsg_serial_in_parallel_out_full;
    localparam int W = 8, N = 4;
    logic clk = 0, rst = 1;
    always #5 clk = ~clk;
    int tests = 0, fails = 0;
    logic force_v = 1, rand_mode = 0, phase5 = 0, yumi_mode = 1;
    logic [W-1:0] sq [3][$];

    task automatic chk(input string name, input int k, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s dut%0d: got %0h expected %0h", name, k, got, exp);
        end
    endtask

    task automatic push(input logic [W-1:0] w);
        for (int k = 0; k < 3; k++) sq[k].push_back(w);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((sq[0].size() + sq[1].size() + sq[2].size()) != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        tests++;
        if (n >= budget) begin
            fails++;
            $display("FAIL timeout: got %0d cycles, limit %0d", n, budget);
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    for (genvar g = 0; g < 3; g++) begin : u
        localparam int HI = (g == 1) ? 1 : 0;
        localparam int MIN = (g == 2) ? 1 : 0;
        logic v, rdy, vo, y, ye = 0, took = 0;
        logic [W-1:0] d;
        logic [N-1:0][W-1:0] dout, e;
        logic [W-1:0] cur[$];
        logic [N*W-1:0] eq[$];
        int rlow = 0, nout = 0;
        assign y = vo & ye;

        bsg_serial_in_parallel_out_full #(
            .width_p(W), .els_p(N), .hi_to_lo_p(HI), .use_minimal_buffering_p(MIN)
        ) dut (
            .clk_i(clk), .reset_i(rst), .valid_i(v), .data_i(d),
            .ready_o(rdy), .valid_o(vo), .data_o(dout), .yumi_i(y)
        );

        initial begin
            v = 0;
            d = 0;
            forever begin
                @(posedge clk);
                #2;
                if (took) void'(sq[g].pop_front());
                v = force_v | (sq[g].size() > 0 && (!rand_mode || $urandom_range(3) != 0));
                d = sq[g].size() > 0 ? sq[g][0] : W'($urandom);
                ye = rand_mode ? 1'($urandom) : yumi_mode;
            end
        end

        always @(negedge clk) begin
            chk("ready", g, 32'(!rst && eq.size() < (MIN != 0 ? 1 : 2)), 32'(rdy));
            chk("valid", g, 32'(vo), 32'(!rst && eq.size() > 0));
            took = v & rdy & !rst;
            if (rst) begin
                cur.delete();
                eq.delete();
            end else begin
                if (phase5 && !rdy) rlow++;
                if (y && vo) begin
                    if (eq.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL data dut%0d: got %0h expected no output", g, dout);
                    end else begin
                        chk("data", g, dout, eq.pop_front());
                        nout++;
                    end
                end
                if (took) begin
                    cur.push_back(d);
                    if (cur.size() == N) begin
                        for (int i = 0; i < N; i++) e[HI != 0 ? N - 1 - i : i] = cur[i];
                        eq.push_back(e);
                        cur.delete();
                    end
                end
            end
        end
    end

    initial begin
        int n0, n2;
        repeat (3) @(posedge clk);
        #1;
        rst = 0;
        force_v = 0;
        for (int i = 1; i <= 4; i++) push(W'(i * 8'h11));
        wait_idle(100);
        chk("one_set", 0, 32'(u[0].nout), 1);
        chk("one_set", 1, 32'(u[1].nout), 1);
        yumi_mode = 0;
        for (int i = 1; i <= 9; i++) push(W'(i * 8'h11));
        repeat (20) @(posedge clk);
        #1;
        chk("stall_left", 0, 32'(sq[0].size()), 1);
        chk("stall_left", 2, 32'(sq[2].size()), 5);
        yumi_mode = 1;
        wait_idle(200);
        push(8'hAA);
        push(8'hBB);
        wait_idle(100);
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        for (int i = 1; i <= 4; i++) push(W'(i));
        wait_idle(100);
        n0 = u[0].nout;
        n2 = u[2].nout;
        u[0].rlow = 0;
        u[1].rlow = 0;
        u[2].rlow = 0;
        phase5 = 1;
        for (int i = 0; i < 12; i++) push(W'($urandom));
        wait_idle(200);
        phase5 = 0;
        chk("ready_low", 0, 32'(u[0].rlow), 0);
        chk("ready_low", 1, 32'(u[1].rlow), 0);
        chk("ready_low", 2, 32'(u[2].rlow), 3);
        chk("outputs", 0, 32'(u[0].nout - n0), 3);
        chk("outputs", 2, 32'(u[2].nout - n2), 3);
        rand_mode = 1;
        for (int i = 0; i < 200; i++) push(W'($urandom));
        wait_idle(5000);
        rand_mode = 0;
        repeat (10) @(posedge clk);
        #1;
        chk("drain", 0, 32'(u[0].eq.size()), 0);
        chk("drain", 1, 32'(u[1].eq.size()), 0);
        chk("drain", 2, 32'(u[2].eq.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
